// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared state, opcode, aluOp and mux-select definitions for the multicycle control
package mc_pkg;

  // Control FSM states; 4-bit encoding is visible on state_o for debug
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  // Instruction classes produced by the opcode decoder
  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_LW      = 3'd1,
    CLS_SW      = 3'd2,
    CLS_BEQ     = 3'd3,
    CLS_J       = 3'd4,
    CLS_IALU    = 3'd5,
    CLS_ILLEGAL = 3'd6
  } instr_class_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  // R-type funct codes that the control resolves itself (shifts/rotate)
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  // aluOp encoding shared with alu_control
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_RTYPE = 4'b0010;
  localparam logic [3:0] ALU_ADDI  = 4'b0011;
  localparam logic [3:0] ALU_ANDI  = 4'b0100;
  localparam logic [3:0] ALU_ORI   = 4'b0101;
  localparam logic [3:0] ALU_SLTI  = 4'b0110;
  localparam logic [3:0] ALU_XORI  = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_ROTR  = 4'b1011;

  // Datapath mux selects
  localparam logic       IORD_PC      = 1'b0;
  localparam logic       IORD_ALUOUT  = 1'b1;
  localparam logic       SRCA_PC      = 1'b0;
  localparam logic       SRCA_A       = 1'b1;
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;
  localparam logic       EXT_SIGN     = 1'b0;
  localparam logic       EXT_ZERO     = 1'b1;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic       REGDST_RT    = 1'b0;
  localparam logic       REGDST_RD    = 1'b1;

  // Registered control word; ir_write and the fetch PC write are gated by mem ready outside it
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_sel;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
    logic       halted;
  } ctrl_t;

  // Moore control word for a state; execute/writeback states take the decoded aluOp and extender
  function automatic ctrl_t state_ctrl(state_t s, logic [3:0] exec_op, logic exec_ext);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.iord      = IORD_PC;
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_src    = PCSRC_ALU;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_IMM_SH2;
        c.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = SRCA_A;
        c.alu_src_b = SRCB_IMM;
        c.ext_sel   = EXT_SIGN;
        c.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.iord     = IORD_ALUOUT;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_dst    = REGDST_RT;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.iord      = IORD_ALUOUT;
      end
      S_REXEC: begin
        c.alu_src_a = SRCA_A;
        c.alu_src_b = SRCB_B;
        c.alu_op    = exec_op;
      end
      S_RWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = REGDST_RD;
      end
      S_IEXEC: begin
        c.alu_src_a = SRCA_A;
        c.alu_src_b = SRCB_IMM;
        c.ext_sel   = exec_ext;
        c.alu_op    = exec_op;
      end
      S_IWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = REGDST_RT;
        c.ext_sel   = exec_ext;
        c.alu_op    = exec_op;
      end
      S_BRANCH: begin
        c.alu_src_a     = SRCA_A;
        c.alu_src_b     = SRCB_B;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_src        = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        c.pc_write = 1'b1;
        c.pc_src   = PCSRC_JUMP;
      end
      S_HALT: begin
        c.halted = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_opdecode.sv
// rtl/multicycle_control_opdecode.sv - opcode/funct decode into instruction class, execute aluOp and extender select
module mc_opdecode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       rs0,
  output logic [2:0] instr_class,
  output logic [3:0] exec_alu_op,
  output logic       exec_ext_sel
);

  instr_class_t cls;

  // Classify the instruction and pick the aluOp/extender used in its execute and writeback states
  always_comb begin
    cls          = CLS_ILLEGAL;
    exec_alu_op  = ALU_ADD;
    exec_ext_sel = EXT_SIGN;
    case (opcode)
      OP_RTYPE: begin
        cls = CLS_R;
        if (funct == FN_SLL) begin
          exec_alu_op = ALU_SLL;
        end else if (funct == FN_SRL) begin
          // IR[21] turns srl into rotate-right
          exec_alu_op = rs0 ? ALU_ROTR : ALU_SRL;
        end else begin
          exec_alu_op = ALU_RTYPE;
        end
      end
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_BEQ:  cls = CLS_BEQ;
      OP_J:    cls = CLS_J;
      OP_ADDI: begin
        cls         = CLS_IALU;
        exec_alu_op = ALU_ADDI;
      end
      OP_ANDI: begin
        cls          = CLS_IALU;
        exec_alu_op  = ALU_ANDI;
        exec_ext_sel = EXT_ZERO;
      end
      OP_ORI: begin
        cls          = CLS_IALU;
        exec_alu_op  = ALU_ORI;
        exec_ext_sel = EXT_ZERO;
      end
      OP_SLTI: begin
        cls         = CLS_IALU;
        exec_alu_op = ALU_SLTI;
      end
      OP_XORI: begin
        cls          = CLS_IALU;
        exec_alu_op  = ALU_XORI;
        exec_ext_sel = EXT_ZERO;
      end
      default: cls = CLS_ILLEGAL;
    endcase
  end

  assign instr_class = cls;

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - main control FSM sequencing the multicycle MIPS datapath
module multicycle_control
  import mc_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit ILLEGAL_HALT  = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       rs0_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       pc_write_cond_o,
  output logic       iord_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic       ext_sel_o,
  output logic [1:0] pc_src_o,
  output logic [3:0] alu_op_o,
  output logic       halted_o,
  output logic [3:0] state_o
);

  state_t       state;
  state_t       next_state;
  ctrl_t        ctrl_q;
  ctrl_t        ctrl_out;
  logic [1:0]   rst_pipe;
  logic         rst_hold;
  logic         ready_eff;
  logic         fetch_done;
  logic [2:0]   class_bits;
  instr_class_t instr_class;
  logic [3:0]   exec_alu_op;
  logic         exec_ext_sel;

  mc_opdecode u_opdecode (
    .opcode       (opcode_i),
    .funct        (funct_i),
    .rs0          (rs0_i),
    .instr_class  (class_bits),
    .exec_alu_op  (exec_alu_op),
    .exec_ext_sel (exec_ext_sel)
  );

  assign instr_class = instr_class_t'(class_bits);

  // With a single-cycle memory every access completes immediately
  assign ready_eff = MEM_HANDSHAKE ? mem_ready_i : 1'b1;

  // Reset synchroniser: asserts with rst_i, releases two clocks after rst_i falls
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rst_pipe <= 2'b11;
    end else begin
      rst_pipe <= {rst_pipe[0], 1'b0};
    end
  end

  assign rst_hold = rst_pipe[1];

  // Next-state sequencing through fetch/decode/execute/memory/writeback
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (ready_eff) next_state = S_DECODE;
      S_DECODE: begin
        case (instr_class)
          CLS_R:          next_state = S_REXEC;
          CLS_LW, CLS_SW: next_state = S_MEMADR;
          CLS_BEQ:        next_state = S_BRANCH;
          CLS_J:          next_state = S_JUMP;
          CLS_IALU:       next_state = S_IEXEC;
          default:        next_state = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR: next_state = (instr_class == CLS_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (ready_eff) next_state = S_MEMWB;
      S_MEMWB:  next_state = S_FETCH;
      S_MEMWR:  if (ready_eff) next_state = S_FETCH;
      S_REXEC:  next_state = S_RWB;
      S_RWB:    next_state = S_FETCH;
      S_IEXEC:  next_state = S_IWB;
      S_IWB:    next_state = S_FETCH;
      S_BRANCH: next_state = S_FETCH;
      S_JUMP:   next_state = S_FETCH;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_FETCH;
    endcase
  end

  // State and registered control word; while the reset release is pending the FETCH word is preloaded
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= S_FETCH;
      ctrl_q <= '0;
    end else if (rst_hold) begin
      state  <= S_FETCH;
      ctrl_q <= state_ctrl(S_FETCH, exec_alu_op, exec_ext_sel);
    end else begin
      state  <= next_state;
      ctrl_q <= state_ctrl(next_state, exec_alu_op, exec_ext_sel);
    end
  end

  // Outputs stay quiet until the synchronised reset has released
  assign ctrl_out   = rst_hold ? '0 : ctrl_q;
  assign fetch_done = ~rst_hold & (state == S_FETCH) & ready_eff;

  assign pc_write_o      = ctrl_out.pc_write | fetch_done;
  assign pc_write_cond_o = ctrl_out.pc_write_cond;
  assign iord_o          = ctrl_out.iord;
  assign mem_read_o      = ctrl_out.mem_read;
  assign mem_write_o     = ctrl_out.mem_write;
  assign ir_write_o      = fetch_done;
  assign reg_dst_o       = ctrl_out.reg_dst;
  assign mem_to_reg_o    = ctrl_out.mem_to_reg;
  assign reg_write_o     = ctrl_out.reg_write;
  assign alu_src_a_o     = ctrl_out.alu_src_a;
  assign alu_src_b_o     = ctrl_out.alu_src_b;
  assign ext_sel_o       = ctrl_out.ext_sel;
  assign pc_src_o        = ctrl_out.pc_src;
  assign alu_op_o        = ctrl_out.alu_op;
  assign halted_o        = ctrl_out.halted;
  assign state_o         = state;

endmodule
